// File: rtl/datapath_pkg.sv
// Shared constants for the datapath and its control unit:
// enable bit positions, bus source codes and ALU operation codes.
package datapath_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int OPC_W_DEF  = 6;

    // Bit positions in write_en / inc_en / clr_en
    localparam int EN_PC     = 1;
    localparam int EN_AR     = 2;
    localparam int EN_IR     = 3;
    localparam int EN_AC     = 4;
    localparam int EN_R      = 5;
    localparam int EN_R4     = 7;
    localparam int EN_R3     = 8;
    localparam int EN_R2     = 9;
    localparam int EN_R1     = 10;
    localparam int EN_DM_WR  = 11;
    localparam int EN_ALU_AC = 12;

    typedef enum logic [3:0] {
        SRC_ZERO    = 4'd0,
        SRC_PC      = 4'd1,
        SRC_AR      = 4'd2,
        SRC_DR      = 4'd3,
        SRC_IR_ADDR = 4'd4,
        SRC_AC      = 4'd5,
        SRC_R       = 4'd6,
        SRC_R1      = 4'd7,
        SRC_R2      = 4'd8,
        SRC_R3      = 4'd9,
        SRC_R4      = 4'd10,
        SRC_R5      = 4'd11,
        SRC_DM      = 4'd12,
        SRC_IM      = 4'd13
    } src_e;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_MUL  = 3'd3,
        ALU_LSH  = 3'd4
    } alu_op_e;

endpackage

// File: rtl/datapath_core_if.sv
// Control and memory signals of the datapath.
// slave: the datapath side; master: control unit plus memories.
interface datapath_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int OPC_W  = 6
);
    logic [2:0]        alu_op;
    logic [15:0]       write_en;
    logic [15:0]       inc_en;
    logic [15:0]       clr_en;
    logic [3:0]        read_en;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_rdata;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [OPC_W-1:0]  instruction;
    logic [15:0]       z;
    logic [DATA_W-1:0] ac_out;

    modport slave (
        input  alu_op, write_en, inc_en, clr_en, read_en,
        input  im_rdata, dm_rdata,
        output im_addr, dm_addr, dm_wdata, dm_we,
        output instruction, z, ac_out
    );

    modport master (
        output alu_op, write_en, inc_en, clr_en, read_en,
        output im_rdata, dm_rdata,
        input  im_addr, dm_addr, dm_wdata, dm_we,
        input  instruction, z, ac_out
    );

endinterface

// File: rtl/datapath_core_alu_unit.sv
// Combinational ALU: a is the accumulator, b is R.
// Results are truncated to DATA_W; unknown ops pass a through.
module alu_unit
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    // Operation select; pass-through keeps AC unchanged on ALU->AC
    always_comb begin
        o_result = i_a;
        case (alu_op_e'(i_op))
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_MUL: o_result = i_a * i_b;
            ALU_LSH: o_result = {i_a[DATA_W-2:0], 1'b0};
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/datapath_core.sv
// Register/bus datapath: PC, AR, IR, AC, R, R1-R4, shared bus and ALU.
// Enables are sampled on posedge; per register clr > write > inc.
module datapath_core
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    datapath_core_if.slave  dp
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_ac;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_r1;
    logic [DATA_W-1:0] r_r2;
    logic [DATA_W-1:0] r_r3;
    logic [DATA_W-1:0] r_r4;

    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_ac_d;
    logic              w_ac_wr;
    logic              w_unused;

    function automatic logic [DATA_W-1:0] reg_next(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] d,
        input logic              clr,
        input logic              wr,
        input logic              inc
    );
        if (clr)
            return '0;
        else if (wr)
            return d;
        else if (inc)
            return cur + DATA_W'(1);
        else
            return cur;
    endfunction

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_ac),
        .i_b      (r_r),
        .i_op     (dp.alu_op),
        .o_result (w_alu)
    );

    // Shared bus: one source selected by read_en, reserved codes read 0
    always_comb begin
        w_bus = '0;
        case (src_e'(dp.read_en))
            SRC_PC:      w_bus = r_pc;
            SRC_AR:      w_bus = r_ar;
            SRC_IR_ADDR: w_bus = r_ir >> OPC_W;
            SRC_AC:      w_bus = r_ac;
            SRC_R:       w_bus = r_r;
            SRC_R1:      w_bus = r_r1;
            SRC_R2:      w_bus = r_r2;
            SRC_R3:      w_bus = r_r3;
            SRC_R4:      w_bus = r_r4;
            SRC_DM:      w_bus = dp.dm_rdata;
            SRC_IM:      w_bus = dp.im_rdata;
            default:     w_bus = '0;
        endcase
    end

    // AC load source: ALU result takes precedence over the bus
    always_comb begin
        w_ac_wr = dp.write_en[EN_AC] | dp.write_en[EN_ALU_AC];
        w_ac_d  = dp.write_en[EN_ALU_AC] ? w_alu : w_bus;
    end

    // Register file update with asynchronous clear to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ar <= '0;
            r_ir <= '0;
            r_ac <= '0;
            r_r  <= '0;
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
            r_r4 <= '0;
        end else begin
            r_pc <= reg_next(r_pc, w_bus, dp.clr_en[EN_PC],
                             dp.write_en[EN_PC], dp.inc_en[EN_PC]);
            r_ar <= reg_next(r_ar, w_bus, dp.clr_en[EN_AR],
                             dp.write_en[EN_AR], dp.inc_en[EN_AR]);
            r_ir <= reg_next(r_ir, w_bus, dp.clr_en[EN_IR],
                             dp.write_en[EN_IR], dp.inc_en[EN_IR]);
            r_ac <= reg_next(r_ac, w_ac_d, dp.clr_en[EN_AC],
                             w_ac_wr, dp.inc_en[EN_AC]);
            r_r  <= reg_next(r_r, w_bus, dp.clr_en[EN_R],
                             dp.write_en[EN_R], dp.inc_en[EN_R]);
            r_r1 <= reg_next(r_r1, w_bus, dp.clr_en[EN_R1],
                             dp.write_en[EN_R1], dp.inc_en[EN_R1]);
            r_r2 <= reg_next(r_r2, w_bus, dp.clr_en[EN_R2],
                             dp.write_en[EN_R2], dp.inc_en[EN_R2]);
            r_r3 <= reg_next(r_r3, w_bus, dp.clr_en[EN_R3],
                             dp.write_en[EN_R3], dp.inc_en[EN_R3]);
            r_r4 <= reg_next(r_r4, w_bus, dp.clr_en[EN_R4],
                             dp.write_en[EN_R4], dp.inc_en[EN_R4]);
        end
    end

    assign dp.im_addr     = r_pc[ADDR_W-1:0];
    assign dp.dm_addr     = r_ar[ADDR_W-1:0];
    assign dp.dm_wdata    = w_bus;
    assign dp.dm_we       = dp.write_en[EN_DM_WR];
    assign dp.instruction = r_ir[OPC_W-1:0];
    assign dp.z           = {15'b0, (r_ac == '0)};
    assign dp.ac_out      = r_ac;

    // Enable bits with no register behind them
    assign w_unused = &{1'b0,
                        dp.write_en[0], dp.write_en[6],
                        dp.write_en[15:13],
                        dp.inc_en[0], dp.inc_en[6],
                        dp.inc_en[15:11],
                        dp.clr_en[0], dp.clr_en[6],
                        dp.clr_en[15:11]};

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed scenarios plus
// random microcode against a register-array reference model.
module tb_datapath_core;

    logic clk;
    logic rst_n;

    datapath_core_if #(
        .DATA_W (16),
        .ADDR_W (10),
        .OPC_W  (6)
    ) dpi ();

    datapath_core #(
        .DATA_W (16),
        .ADDR_W (10),
        .OPC_W  (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dpi.slave)
    );

    int n_err;
    int n_chk;

    // Model registers indexed by their enable bit number
    logic [15:0] m [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bus(input int sel,
                                            input logic [15:0] im,
                                            input logic [15:0] dm);
        logic [15:0] ir;
        ir = m[3];
        case (sel)
            1:       return m[1];
            2:       return m[2];
            4:       return 16'(int'(ir) / 64);
            5:       return m[4];
            6:       return m[5];
            7:       return m[10];
            8:       return m[9];
            9:       return m[8];
            10:      return m[7];
            12:      return dm;
            13:      return im;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_alu(input int op,
                                            input longint a,
                                            input longint b);
        case (op)
            1:       return 16'((a + b) % 65536);
            2:       return 16'((a - b + 65536) % 65536);
            3:       return 16'((a * b) % 65536);
            4:       return 16'((a * 2) % 65536);
            default: return 16'(a);
        endcase
    endfunction

    task automatic check_outs(input string tag);
        logic [15:0] pc;
        logic [15:0] ar;
        logic [15:0] ir;
        pc = m[1];
        ar = m[2];
        ir = m[3];
        check({tag, ".im_addr"}, 32'(dpi.im_addr), 32'(pc[9:0]));
        check({tag, ".dm_addr"}, 32'(dpi.dm_addr), 32'(ar[9:0]));
        check({tag, ".instr"}, 32'(dpi.instruction), 32'(ir[5:0]));
        check({tag, ".ac"}, 32'(dpi.ac_out), 32'(m[4]));
        check({tag, ".z"}, 32'(dpi.z), (m[4] == 0) ? 32'd1 : 32'd0);
    endtask

    // One microcode cycle: drive on negedge, check bus, clock, check regs
    task automatic cyc(input logic [15:0] we,
                       input logic [15:0] ie,
                       input logic [15:0] ce,
                       input logic [3:0]  re,
                       input logic [2:0]  op,
                       input logic [15:0] imd,
                       input logic [15:0] dmd,
                       input string       tag);
        logic [15:0] bus;
        logic [15:0] alu;
        logic [15:0] nx [16];
        int idx [9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};
        @(negedge clk);
        dpi.write_en = we;
        dpi.inc_en   = ie;
        dpi.clr_en   = ce;
        dpi.read_en  = re;
        dpi.alu_op   = op;
        dpi.im_rdata = imd;
        dpi.dm_rdata = dmd;
        #1;
        bus = ref_bus(int'(re), imd, dmd);
        alu = ref_alu(int'(op), longint'(m[4]), longint'(m[5]));
        check({tag, ".wdata"}, 32'(dpi.dm_wdata), 32'(bus));
        check({tag, ".we"}, 32'(dpi.dm_we), 32'(we[11]));
        nx = m;
        foreach (idx[k]) begin
            int i;
            i = idx[k];
            if (ce[i])
                nx[i] = 16'h0000;
            else if (i == 4 && we[12])
                nx[i] = alu;
            else if (we[i])
                nx[i] = bus;
            else if (ie[i])
                nx[i] = 16'((int'(m[i]) + 1) % 65536);
        end
        @(posedge clk);
        #1;
        if (rst_n)
            m = nx;
        check_outs(tag);
    endtask

    task automatic ld(input int bitn, input logic [15:0] v,
                      input string tag);
        cyc(16'(1 << bitn), 16'h0, 16'h0, 4'd13, 3'd0, v, 16'h0, tag);
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        foreach (m[i]) m[i] = 16'h0000;
        rst_n        = 1'b0;
        dpi.write_en = 16'h0;
        dpi.inc_en   = 16'h0;
        dpi.clr_en   = 16'h0;
        dpi.read_en  = 4'd0;
        dpi.alu_op   = 3'd0;
        dpi.im_rdata = 16'h0;
        dpi.dm_rdata = 16'h0;

        // Reset holds everything at zero despite enables
        cyc(16'hFFFF, 16'h0, 16'h0, 4'd13, 3'd0, 16'h1234, 16'h0, "rst");
        check("rst_z", 32'(dpi.z), 32'h0001);
        check("rst_pc", 32'(dpi.im_addr), 32'h0);
        rst_n = 1'b1;
        cyc(16'hFFFF, 16'h0, 16'h0, 4'd13, 3'd0, 16'h1234, 16'h0, "rel");
        check("rel_instr", 32'(dpi.instruction), 32'h34);
        check("rel_ac", 32'(dpi.ac_out), 32'h0);

        // Load via DM
        ld(4, 16'h0005, "ac5");
        cyc(16'h0004, 16'h0, 16'h0, 4'd5, 3'd0, 16'h0, 16'h0, "ar");
        check("ar5", 32'(dpi.dm_addr), 32'h5);
        cyc(16'h0010, 16'h0, 16'h0, 4'd12, 3'd0, 16'h0, 16'h00A0, "dmld");
        check("dm_ac", 32'(dpi.ac_out), 32'h00A0);
        check("dm_z", 32'(dpi.z), 32'h0);

        // ALU wrap cases
        ld(4, 16'hFFFF, "acff");
        ld(5, 16'h0002, "r2");
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 3'd1, 16'h0, 16'h0, "add");
        check("add_wrap", 32'(dpi.ac_out), 32'h0001);
        ld(4, 16'h8001, "ac81");
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 3'd4, 16'h0, 16'h0, "lsh");
        check("lsh", 32'(dpi.ac_out), 32'h0002);
        ld(4, 16'h0100, "ac100");
        ld(5, 16'h0100, "r100");
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 3'd3, 16'h0, 16'h0, "mul");
        check("mul_lo", 32'(dpi.ac_out), 32'h0000);
        check("mul_z", 32'(dpi.z), 32'h0001);
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 3'd6, 16'h0, 16'h0, "nop");
        ld(4, 16'h0003, "ac3");
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 3'd2, 16'h0, 16'h0, "sub");
        check("sub_wrap", 32'(dpi.ac_out), 32'hFF03);

        // PC priority
        ld(1, 16'h0007, "pc7");
        ld(3, 16'h0A40, "ir");
        cyc(16'h0002, 16'h0002, 16'h0, 4'd4, 3'd0, 16'h0, 16'h0, "jmp");
        check("jmp_pc", 32'(dpi.im_addr), 32'h029);
        ld(1, 16'hFFFF, "pcff");
        cyc(16'h0, 16'h0002, 16'h0, 4'd0, 3'd0, 16'h0, 16'h0, "incw");
        check("inc_wrap", 32'(dpi.im_addr), 32'h0);
        ld(1, 16'h0055, "pc55");
        cyc(16'h0002, 16'h0, 16'h0002, 4'd13, 3'd0, 16'h1111, 16'h0,
            "clrw");
        check("clr_win", 32'(dpi.im_addr), 32'h0);

        // Register moves and DM store
        ld(4, 16'h0033, "ac33");
        cyc(16'h0400, 16'h0, 16'h0, 4'd5, 3'd0, 16'h0, 16'h0, "r1");
        cyc(16'h0, 16'h0, 16'h0010, 4'd0, 3'd0, 16'h0, 16'h0, "clrac");
        check("clr_ac", 32'(dpi.ac_out), 32'h0);
        cyc(16'h0010, 16'h0, 16'h0, 4'd7, 3'd0, 16'h0, 16'h0, "r1ac");
        check("r1_ac", 32'(dpi.ac_out), 32'h0033);
        @(negedge clk);
        dpi.write_en = 16'h0800;
        dpi.inc_en   = 16'h0;
        dpi.clr_en   = 16'h0;
        dpi.read_en  = 4'd5;
        #1;
        check("st_we", 32'(dpi.dm_we), 32'h1);
        check("st_wdata", 32'(dpi.dm_wdata), 32'h0033);

        // Random microcode
        for (int t = 0; t < 400; t++) begin
            cyc(16'($urandom), 16'($urandom),
                16'($urandom & $urandom & $urandom),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                16'($urandom), 16'($urandom), "rnd");
        end

        // Asynchronous reset between edges
        ld(1, 16'h0123, "pcpre");
        @(negedge clk);
        dpi.write_en = 16'h0;
        dpi.clr_en   = 16'h0;
        dpi.inc_en   = 16'h0002;
        #2;
        rst_n = 1'b0;
        #1;
        foreach (m[i]) m[i] = 16'h0000;
        check("arst_pc", 32'(dpi.im_addr), 32'h0);
        check("arst_z", 32'(dpi.z), 32'h0001);
        check("arst_instr", 32'(dpi.instruction), 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold", 32'(dpi.im_addr), 32'h0);
        rst_n = 1'b1;
        cyc(16'h0, 16'h0002, 16'h0, 4'd0, 3'd0, 16'h0, 16'h0, "post");
        check("post_inc", 32'(dpi.im_addr), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Register/bus datapath that executes the control unit's microcode: receives alu_op, write_en, inc_en, clr_en and read_en, and returns instruction and z.
- Holds PC, AR, IR, AC, R and R1-R4, a single shared bus mux, the ALU, and the IM/DM port wiring.
- Control state changes on negedge clk; this block samples all enables on posedge clk, so enables are stable half a cycle before use.

Parameters:
- DATA_W, 16, width of bus and all registers
- ADDR_W, 10, width of im_addr/dm_addr (low bits of PC/AR)
- OPC_W, 6, opcode field width in IR

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- alu_op  in  3  0 none, 1 add, 2 sub, 3 mult, 4 lshift
- write_en  in  16  load enables, bit map below
- inc_en  in  16  increment enables, same bit map
- clr_en  in  16  clear enables, same bit map
- read_en  in  4  bus source select
- im_addr  out  ADDR_W  instruction memory address = PC[ADDR_W-1:0]
- im_rdata  in  DATA_W  instruction memory data, combinational
- dm_addr  out  ADDR_W  data memory address = AR[ADDR_W-1:0]
- dm_rdata  in  DATA_W  data memory read data, combinational
- dm_wdata  out  DATA_W  = bus
- dm_we  out  1  = write_en[11]
- instruction  out  OPC_W  = IR[OPC_W-1:0]
- z  out  16  {15'b0, AC==0}
- ac_out  out  DATA_W  AC value, for debug/result readout

Behaviour:
- Enable bit map, for write/inc/clr:
  - 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1, 11 DM write, 12 ALU->AC.
  - Bits 0, 6, 13-15 are ignored.
  - inc/clr on bits 11/12 are ignored.
- Bus source by read_en:
  - 0: zero
  - 1: PC
  - 2: AR
  - 3: zero (DR reserved)
  - 4: IR >> OPC_W, zero-extended (address field)
  - 5: AC
  - 6: R
  - 7: R1
  - 8: R2
  - 9: R3
  - 10: R4
  - 11: zero (R5 reserved)
  - 12: dm_rdata
  - 13: im_rdata
  - 14-15: zero
- Per-register update on posedge clk, priority clr > write > inc:
  - clr: reg <= 0
  - write: reg <= bus
  - inc: reg <= reg+1, modulo 2^DATA_W (0xFFFF wraps to 0)
  - no enable asserted: hold
- AC write sources:
  - write_en[12] loads ALU result.
  - If write_en[4] and write_en[12] are both set, write_en[12] wins.
  - clr_en[4] still beats both.
- ALU operands are AC (a) and R (b). Result is combinational and truncated to DATA_W:
  - add: a+b
  - sub: a-b, two's complement wrap
  - mult: low DATA_W bits of a*b
  - lshift: a<<1, MSB dropped, LSB 0
  - alu_op 0 or 5-7: result = a; with write_en[12] set, AC is unchanged.
- Write-plus-increment on the same register: write wins, no increment.
  - Example: jump state with write_en[1] and inc_en[1] gives PC = bus exactly.
- Output timing:
  - z and instruction are combinational from registers and update in the same cycle as the register edge.
  - dm_we is purely combinational from write_en; the memory samples dm_wdata on its own posedge.
- Reset (rst_n low, asynchronous): all registers 0.
  - Hence im_addr=0, dm_addr=0, instruction=0, ac_out=0, z=16'h0001, dm_wdata=0 (read_en-driven).
  - Reset asserted mid-operation clears immediately, regardless of enables.
  - First enable honoured is at the first posedge after rst_n rises.

Decomposition:
- Shared package datapath_pkg:
  - enable bit-index constants (EN_PC=1 ... EN_ALU_AC=12)
  - read_en source codes (SRC_PC=1 ... SRC_IM=13)
  - alu_op codes (ALU_ADD=1 ... ALU_LSH=4)
  - Both control and datapath_core use these.
- Sub-module alu_unit: combinational, inputs a, b, op; output result.
- Registers and bus mux stay in datapath_core.

Test Plan:
- Reset: rst_n=0 with write_en=16'hFFFF, read_en=13, im_rdata=16'h1234 -> all registers stay 0, z=16'h0001; release, one edge -> IR=16'h1234, instruction=6'h34.
- Load via DM: AC=16'h0005, read_en=5, write_en[2] -> AR=5; then dm_rdata=16'h00A0, read_en=12, write_en[4] -> AC=16'h00A0, z=0.
- ALU wrap: AC=16'hFFFF, R=16'h0002.
  - alu_op=1 with write_en[12] -> AC=16'h0001.
  - Reload AC=16'h8001, alu_op=4 -> AC=16'h0002.
  - AC=16'h0100, R=16'h0100, alu_op=3 -> AC=16'h0000, z=16'h0001.
- Priority: PC=16'h0007, IR=16'h0A40, read_en=4, write_en[1]+inc_en[1] -> PC=16'h0029.
  - PC=16'hFFFF, inc_en[1] -> PC=0.
  - clr_en[1]+write_en[1] -> PC=0.
- Register moves: AC=16'h0033, write_en[10] -> R1=16'h0033; clr_en[4] -> AC=0; read_en=7, write_en[4] -> AC=16'h0033; DM store with read_en=5, write_en[11] -> dm_we=1, dm_wdata=16'h0033.
- Async reset mid-op: assert rst_n low between edges while inc_en[1] is held -> PC=0 immediately, with no clk edge needed.
